fetch_arbiter: RTL and testbench
================================

Name: fetch_arbiter

Overview:
- Shares the single Avalon-MM burst read master towards SDRAM between two frame-fetch requesters: requester 0 is the background loader, requester 1 is the sprite/tile loader.
- Accepts one burst request at a time and drives the Avalon command phase.
- Counts the returning beats and steers readdatavalid to the granted requester.
- Sits between the loaders' FIFO-fill logic and the SDRAM controller port.

Parameters:
- ADDR_W, 30, word address width.
- DATA_W, 32, read data width.
- BURST_W, 5, burstcount width (max burst 16).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- r0_req  in  1  requester 0 burst request (level, held until r0_grant)
- r0_address  in  ADDR_W  requester 0 start address
- r0_burstcount  in  BURST_W  requester 0 beats; legal range 1..16
- r0_grant  out  1  one-cycle pulse when the command is accepted by the slave
- r0_rdvalid  out  1  beat valid for requester 0
- r0_done  out  1  one-cycle pulse on the last beat of requester 0's burst
- r1_req, r1_address, r1_burstcount, r1_grant, r1_rdvalid, r1_done: same as requester 0
- rd_data  out  DATA_W  registered copy of m_readdata, shared by both requesters
- m_read  out  1  Avalon read
- m_chipselect  out  1  Avalon chipselect
- m_byteenable  out  4  Avalon byteenable; constant 4'hF
- m_address  out  ADDR_W  Avalon address
- m_burstcount  out  BURST_W  Avalon burstcount
- m_beginbursttransfer  out  1  Avalon begin-burst strobe
- m_waitrequest  in  1  Avalon waitrequest
- m_readdatavalid  in  1  Avalon readdatavalid
- m_readdata  in  DATA_W  Avalon readdata
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - All outputs 0 except m_byteenable = 4'hF.
  - State = IDLE; last_grant = 1 (so requester 0 wins first).
  - Reset mid-burst aborts immediately; stray readdatavalid beats after reset are ignored in IDLE.
- FSM states: IDLE, CMD, DATA.
- IDLE:
  - If any req is high, select a winner, latch its address and burstcount, go to CMD next cycle.
  - Latency from req to m_read = 1 cycle.
- CMD:
  - m_read and m_chipselect high; m_address and m_burstcount come from the latched values.
  - m_beginbursttransfer is high only on the first CMD cycle.
  - Hold all command signals stable while m_waitrequest = 1.
  - On the cycle m_waitrequest = 0: pulse the winner's grant, drop m_read, load the beat counter with burstcount, update last_grant, go to DATA.
- DATA:
  - Each m_readdatavalid: register rd_data, pulse the winner's rdvalid 1 cycle later (aligned with rd_data), decrement the counter.
  - When the counter goes 1 -> 0: pulse the winner's done together with the last rdvalid, go to IDLE.
  - Next arbitration is possible the cycle after IDLE is entered. Back-to-back bursts have a gap of at least 1 idle cycle.
- Arbitration, default round-robin:
  - If both requesters are asserted in IDLE, the one not equal to last_grant wins.
  - A single requester always wins.
- Simultaneous events:
  - A req that drops during CMD has no effect; the latched command completes.
  - readdatavalid during CMD cannot occur (read was not accepted); it is ignored.
- Beat counter width is BURST_W. A burstcount of 0 is illegal; it is treated as 16 beats.
- The non-granted requester sees no rdvalid, no grant and no done.

Optional Feature:
- Macro: FETCH_ARB_BG_PRIORITY_EN.
- Defined: requester 0 (background) has strict priority. Whenever r0_req is high in IDLE it wins, regardless of last_grant. This guarantees background line fill under display load.
- Undefined: round-robin as described above. last_grant logic is still present but ignored when the macro is defined.

Decomposition:
- Package fetch_arb_pkg holds:
  - the state enum (IDLE, CMD, DATA);
  - the requester-index typedef;
  - the constants BYTEEN_ALL = 4'hF and MAX_BURST = 16.
- Natural sub-module: fetch_arb_select, a combinational winner selection from (r0_req, r1_req, last_grant) including the macro branch. The FSM, counter and datapath stay in the top level.

Test Plan:
- Single request: r0_req with address 0x100, burstcount 8, waitrequest 0 -> m_read high for 1 cycle with m_beginbursttransfer; r0_grant pulses; 8 data beats 0xA0..0xA7 yield 8 r0_rdvalid with matching rd_data; r0_done on beat 8; r1 outputs stay 0.
- Waitrequest stall: r1_req with burstcount 4 and waitrequest high for 3 cycles -> m_read, m_address and m_burstcount are stable for 4 cycles; m_beginbursttransfer is high only in the first cycle; r1_grant pulses on the accept cycle.
- Contention, round-robin: r0 and r1 both held high for 4 bursts -> grant order r0, r1, r0, r1. With FETCH_ARB_BG_PRIORITY_EN defined -> r0, r0, r0, r0.
- Mid-burst reset: assert reset after 3 of 16 beats -> all outputs return to reset values asynchronously; 13 late readdatavalid beats produce no rdvalid; the next request runs normally.
- Max burst and gaps: burstcount 16 with readdatavalid toggling 1,0,1,0 -> exactly 16 rdvalid and 1 done; counter has no wrap; busy falls the cycle after done.
- Zero burstcount: r0_burstcount 0 -> m_burstcount 0 is driven; the block expects 16 beats before returning to IDLE.

Source files
------------

// File: rtl/fetch_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM burst-read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the FSM state encoding, the requester index type and the fixed Avalon
// constants used by fetch_arbiter and fetch_arb_select.
package fetch_arb_pkg;

    // FSM state encoding, kept as plain constants so existing code that
    // compares raw state values keeps working.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CMD  = 2'd1;
    localparam state_t DATA = 2'd2;

    // Requester index: 0 = background loader, 1 = sprite/tile loader.
    typedef logic req_idx_t;
    localparam req_idx_t REQ_BG  = 1'b0;
    localparam req_idx_t REQ_SPR = 1'b1;

    // Every read fetches full words.
    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    // Largest burst the SDRAM port supports; a burstcount of 0 means this many.
    localparam int MAX_BURST = 16;

endpackage : fetch_arb_pkg

// File: rtl/fetch_arb_select.sv
// Combinational winner selection between the two fetch requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller samples the result only when it can start a burst.
//
// Ports:
//   r0_req, r1_req  - level requests from the background and sprite loaders
//   last_grant      - requester that won the previous arbitration
//   any_req         - at least one request is pending
//   winner          - index of the requester that should be served next
//
// Build option: FETCH_ARB_BG_PRIORITY_EN gives requester 0 strict priority;
// without it the two requesters alternate when both are waiting.
module fetch_arb_select
    import fetch_arb_pkg::*;
(
    input  logic     r0_req,
    input  logic     r1_req,
    input  req_idx_t last_grant,
    output logic     any_req,
    output req_idx_t winner
);

`ifdef FETCH_ARB_BG_PRIORITY_EN
    // Round-robin history is kept by the top level but has no say here.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        any_req = r0_req | r1_req;
        winner  = REQ_BG;
`ifdef FETCH_ARB_BG_PRIORITY_EN
        // Background line fill must never starve under sprite load.
        if (r0_req) begin
            winner = REQ_BG;
        end else if (r1_req) begin
            winner = REQ_SPR;
        end
`else
        // Under contention the requester that did not win last time goes next.
        if (r0_req && r1_req) begin
            winner = ~last_grant;
        end else if (r1_req) begin
            winner = REQ_SPR;
        end else begin
            winner = REQ_BG;
        end
`endif
    end

endmodule : fetch_arb_select

// File: rtl/fetch_arbiter.sv
// Shares one Avalon-MM burst read master between the background and sprite loaders.
// Latency: req -> m_read 1 cycle; m_readdatavalid -> rdvalid/rd_data 1 cycle.
// Backpressure: command held stable while m_waitrequest; requesters hold req until grant.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   rN_req/address/burstcount
//                         - per-requester burst request (level, held until rN_grant)
//   rN_grant              - one-cycle pulse in the cycle the slave accepts the command
//   rN_rdvalid, rN_done   - beat strobe and last-beat strobe, aligned with rd_data
//   rd_data               - registered read data shared by both requesters
//   m_*                   - Avalon-MM burst read master towards the SDRAM controller
//   busy                  - high whenever a burst is in flight (state != IDLE)
//
// Build option: FETCH_ARB_BG_PRIORITY_EN (see fetch_arb_select) gives requester 0
// strict priority; default is round-robin.
module fetch_arbiter
    import fetch_arb_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 5
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               r0_req,
    input  logic [ADDR_W-1:0]  r0_address,
    input  logic [BURST_W-1:0] r0_burstcount,
    output logic               r0_grant,
    output logic               r0_rdvalid,
    output logic               r0_done,

    input  logic               r1_req,
    input  logic [ADDR_W-1:0]  r1_address,
    input  logic [BURST_W-1:0] r1_burstcount,
    output logic               r1_grant,
    output logic               r1_rdvalid,
    output logic               r1_done,

    output logic [DATA_W-1:0]  rd_data,

    output logic               m_read,
    output logic               m_chipselect,
    output logic [3:0]         m_byteenable,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BURST_W-1:0] m_burstcount,
    output logic               m_beginbursttransfer,
    input  logic               m_waitrequest,
    input  logic               m_readdatavalid,
    input  logic [DATA_W-1:0]  m_readdata,

    output logic               busy
);

    state_t             state;
    req_idx_t           winner_q;      // requester owning the current burst
    req_idx_t           last_grant;    // round-robin history
    req_idx_t           sel_winner;
    logic               any_req;
    logic [BURST_W-1:0] beat_cnt;      // beats still expected in DATA
    logic [BURST_W-1:0] beats_to_load;
    logic               accept;
    logic               beat;
    logic               last_beat;

    fetch_arb_select u_select (
        .r0_req     (r0_req),
        .r1_req     (r1_req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (sel_winner)
    );

    // The slave takes the command on the first CMD cycle without waitrequest.
    assign accept = (state == CMD) && !m_waitrequest;

    // Beats only count while a burst is outstanding. Once the counter has hit
    // zero any further readdatavalid is spurious and must not wrap the counter.
    assign beat      = (state == DATA) && m_readdatavalid && (beat_cnt != '0);
    assign last_beat = beat && (beat_cnt == BURST_W'(1));

    // burstcount 0 is not a legal Avalon value; treat it as the maximum burst
    // so the arbiter never hangs waiting for a zero-length transfer.
    assign beats_to_load = (m_burstcount == '0) ? BURST_W'(MAX_BURST) : m_burstcount;

    assign m_chipselect = m_read;
    assign m_byteenable = BYTEEN_ALL;
    assign busy         = (state != IDLE);

    assign r0_grant = accept && (winner_q == REQ_BG);
    assign r1_grant = accept && (winner_q == REQ_SPR);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (!m_waitrequest) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    // Stay one extra cycle after the last beat so done is
                    // presented while busy is still high; busy drops the
                    // following cycle and arbitration resumes from IDLE.
                    if (beat_cnt == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command phase: latch the winner's request and drive Avalon
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner_q             <= REQ_BG;
            last_grant           <= REQ_SPR;   // so requester 0 wins the first contention
            m_address            <= '0;
            m_burstcount         <= '0;
            m_read               <= 1'b0;
            m_beginbursttransfer <= 1'b0;
        end else begin
            // The begin-burst strobe marks only the first command cycle,
            // even when the slave stalls the command with waitrequest.
            m_beginbursttransfer <= 1'b0;

            if ((state == IDLE) && any_req) begin
                winner_q             <= sel_winner;
                m_address            <= (sel_winner == REQ_SPR) ? r1_address : r0_address;
                m_burstcount         <= (sel_winner == REQ_SPR) ? r1_burstcount : r0_burstcount;
                m_read               <= 1'b1;
                m_beginbursttransfer <= 1'b1;
            end

            if (accept) begin
                m_read     <= 1'b0;
                last_grant <= winner_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data phase: count beats, register data, steer strobes to the owner
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt   <= '0;
            rd_data    <= '0;
            r0_rdvalid <= 1'b0;
            r1_rdvalid <= 1'b0;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;
        end else begin
            r0_rdvalid <= 1'b0;
            r1_rdvalid <= 1'b0;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;

            if (accept) begin
                beat_cnt <= beats_to_load;
            end else if (beat) begin
                beat_cnt <= beat_cnt - BURST_W'(1);
            end

            if (beat) begin
                rd_data    <= m_readdata;
                r0_rdvalid <= (winner_q == REQ_BG);
                r1_rdvalid <= (winner_q == REQ_SPR);
                r0_done    <= last_beat && (winner_q == REQ_BG);
                r1_done    <= last_beat && (winner_q == REQ_SPR);
            end
        end
    end

endmodule : fetch_arbiter

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: cycle tables for single and stalled bursts,
// plus hand sequences for contention, max/zero burst and mid-burst reset.
module tb_fetch_arbiter;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               r0_req, r1_req;
    logic [ADDR_W-1:0]  r0_address, r1_address;
    logic [BURST_W-1:0] r0_burstcount, r1_burstcount;
    logic               r0_grant, r0_rdvalid, r0_done;
    logic               r1_grant, r1_rdvalid, r1_done;
    logic [DATA_W-1:0]  rd_data;
    logic               m_read, m_chipselect, m_beginbursttransfer;
    logic [3:0]         m_byteenable;
    logic [ADDR_W-1:0]  m_address;
    logic [BURST_W-1:0] m_burstcount;
    logic               m_waitrequest, m_readdatavalid;
    logic [DATA_W-1:0]  m_readdata;
    logic               busy;

    always #5 clk = ~clk;

    fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_address(r0_address), .r0_burstcount(r0_burstcount),
        .r0_grant(r0_grant), .r0_rdvalid(r0_rdvalid), .r0_done(r0_done),
        .r1_req(r1_req), .r1_address(r1_address), .r1_burstcount(r1_burstcount),
        .r1_grant(r1_grant), .r1_rdvalid(r1_rdvalid), .r1_done(r1_done),
        .rd_data(rd_data),
        .m_read(m_read), .m_chipselect(m_chipselect), .m_byteenable(m_byteenable),
        .m_address(m_address), .m_burstcount(m_burstcount),
        .m_beginbursttransfer(m_beginbursttransfer),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
        .m_readdata(m_readdata), .busy(busy)
    );

    // One row = one clock cycle: inputs for the cycle and the outputs expected in it.
    // fl = {m_read, m_beginbursttransfer, r0_grant, r1_grant, r0_rdvalid,
    //       r1_rdvalid, r0_done, r1_done, busy}
    typedef struct packed {
        logic        r0_req;
        logic        r1_req;
        logic        wr;
        logic        rdv;
        logic [31:0] rdata;
        logic [8:0]  fl;
        logic [29:0] a;
        logic [4:0]  b;
        logic [31:0] rd;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r0, input logic r1, input logic wr, input logic rdv,
                                input logic [31:0] rdata, input logic [8:0] fl,
                                input logic [29:0] a, input logic [4:0] b, input logic [31:0] rd);
        vec_t v;
        v.r0_req = r0; v.r1_req = r1; v.wr = wr; v.rdv = rdv; v.rdata = rdata;
        v.fl = fl; v.a = a; v.b = b; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ctl"}, 64'({m_read, m_chipselect, m_beginbursttransfer, r0_grant, r0_rdvalid,
                               r0_done, r1_grant, r1_rdvalid, r1_done, busy}), 64'd0);
        chk({tag, " rd_data"}, 64'(rd_data), 64'd0);
        chk({tag, " addr/bc"}, 64'({m_address, m_burstcount}), 64'd0);
        chk({tag, " byteen"}, 64'(m_byteenable), 64'hF);
    endtask

    task automatic run_table(input string tag, input vec_t t[$]);
        foreach (t[i]) begin
            @(negedge clk);
            r0_req          = t[i].r0_req;
            r1_req          = t[i].r1_req;
            m_waitrequest   = t[i].wr;
            m_readdatavalid = t[i].rdv;
            m_readdata      = t[i].rdata;
            #2;
            chk($sformatf("%s[%0d] flags", tag, i),
                64'({m_read, m_chipselect, m_beginbursttransfer, r0_grant, r1_grant,
                     r0_rdvalid, r1_rdvalid, r0_done, r1_done, busy}),
                64'({t[i].fl[8], t[i].fl}));
            chk($sformatf("%s[%0d] addr", tag, i), 64'(m_address), 64'(t[i].a));
            chk($sformatf("%s[%0d] bc", tag, i), 64'(m_burstcount), 64'(t[i].b));
            chk($sformatf("%s[%0d] rd_data", tag, i), 64'(rd_data), 64'(t[i].rd));
        end
        m_readdatavalid = 1'b0;
        m_waitrequest   = 1'b0;
    endtask

    // Runs one burst for requester 'who'; data word k is {2'b01, addr} + k.
    // gap=1 feeds readdatavalid as 1,0,1,0,...; 'beats' may exceed the burst length.
    task automatic burst(input logic who, input logic [29:0] addr, input logic [4:0] bc,
                         input int beats, input logic gap,
                         output logic granted, output logic [4:0] bc_seen,
                         output int nv, output int nd, output int done_at,
                         output int stray, output int bad_rd,
                         output logic busy_at_done, output logic busy_after);
        logic [31:0] base;
        int          fed;
        logic        phase;
        int          done_c;
        base = {2'b01, addr};
        granted = 1'b0; bc_seen = '0; nv = 0; nd = 0; done_at = -1; stray = 0; bad_rd = 0;
        busy_at_done = 1'b0; busy_after = 1'b1; fed = 0; phase = 1'b0; done_c = -10;
        if (who) begin r1_address = addr; r1_burstcount = bc; end
        else     begin r0_address = addr; r0_burstcount = bc; end
        for (int c = 0; c < 20 && !granted; c++) begin
            @(negedge clk);
            r0_req = !who; r1_req = who; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
            #2;
            if (who ? r1_grant : r0_grant) begin granted = 1'b1; bc_seen = m_burstcount; end
            if (who ? r0_grant : r1_grant) stray++;
        end
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            r0_req = 1'b0; r1_req = 1'b0;
            m_readdatavalid = (fed < beats) && !phase;
            m_readdata      = base + 32'(fed);
            if (m_readdatavalid) fed++;
            if (gap) phase = !phase;
            #2;
            if (c == done_c + 1) busy_after = busy;
            if (who ? r1_rdvalid : r0_rdvalid) begin
                nv++;
                if (rd_data !== base + 32'(nv - 1)) bad_rd++;
            end
            if (who ? r1_done : r0_done) begin
                nd++; done_at = nv; busy_at_done = busy; done_c = c;
            end
            if (r0_grant | r1_grant | (who ? (r0_rdvalid | r0_done) : (r1_rdvalid | r1_done)))
                stray++;
        end
        m_readdatavalid = 1'b0;
    endtask

    initial begin : main
        logic       granted, busy_at_done, busy_after, got, drained;
        logic [4:0] bc_seen;
        int         nv, nd, done_at, stray, bad_rd, ng, both;
        logic       order [4];
        logic [3:0] exp_order;

        reset = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0;
        r0_address = '0; r1_address = '0; r0_burstcount = '0; r1_burstcount = '0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        repeat (2) @(negedge clk);
        #2;
        chk_reset("por");
        @(negedge clk);
        reset = 1'b0;

        // Single request from r0: 8 beats 0xA0..0xA7.
        r0_address = 30'h100; r0_burstcount = 5'd8;
        r1_address = 30'h200; r1_burstcount = 5'd4;
        t1.push_back(mk(1, 0, 0, 0, 32'h0,  9'b000000000, 30'h0,   5'd0, 32'h0));
        t1.push_back(mk(1, 0, 0, 0, 32'h0,  9'b111000001, 30'h100, 5'd8, 32'h0));
        t1.push_back(mk(0, 0, 0, 1, 32'hA0, 9'b000000001, 30'h100, 5'd8, 32'h0));
        for (int k = 1; k < 8; k++)
            t1.push_back(mk(0, 0, 0, 1, 32'hA0 + 32'(k), 9'b000010001, 30'h100, 5'd8,
                            32'hA0 + 32'(k - 1)));
        t1.push_back(mk(0, 0, 0, 0, 32'h0,  9'b000010101, 30'h100, 5'd8, 32'hA7));
        t1.push_back(mk(0, 0, 0, 0, 32'h0,  9'b000000000, 30'h100, 5'd8, 32'hA7));
        run_table("single", t1);

        // r1 with waitrequest high for 3 cycles: command stable for 4 cycles.
        t2.push_back(mk(0, 1, 1, 0, 32'h0,  9'b000000000, 30'h100, 5'd8, 32'hA7));
        t2.push_back(mk(0, 1, 1, 0, 32'h0,  9'b110000001, 30'h200, 5'd4, 32'hA7));
        t2.push_back(mk(0, 1, 1, 0, 32'h0,  9'b100000001, 30'h200, 5'd4, 32'hA7));
        t2.push_back(mk(0, 1, 1, 0, 32'h0,  9'b100000001, 30'h200, 5'd4, 32'hA7));
        t2.push_back(mk(0, 1, 0, 0, 32'h0,  9'b100100001, 30'h200, 5'd4, 32'hA7));
        t2.push_back(mk(0, 0, 0, 1, 32'hB0, 9'b000000001, 30'h200, 5'd4, 32'hA7));
        t2.push_back(mk(0, 0, 0, 1, 32'hB1, 9'b000001001, 30'h200, 5'd4, 32'hB0));
        t2.push_back(mk(0, 0, 0, 1, 32'hB2, 9'b000001001, 30'h200, 5'd4, 32'hB1));
        t2.push_back(mk(0, 0, 0, 1, 32'hB3, 9'b000001001, 30'h200, 5'd4, 32'hB2));
        t2.push_back(mk(0, 0, 0, 0, 32'h0,  9'b000001011, 30'h200, 5'd4, 32'hB3));
        t2.push_back(mk(0, 0, 0, 0, 32'h0,  9'b000000000, 30'h200, 5'd4, 32'hB3));
        run_table("stall", t2);

        // Contention: both held for 4 one-beat bursts; r1 won last, so r0 goes first.
        r0_address = 30'h10; r0_burstcount = 5'd1;
        r1_address = 30'h20; r1_burstcount = 5'd1;
        ng = 0; both = 0;
        for (int k = 0; k < 4; k++) order[k] = 1'bx;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            r0_req = 1'b1; r1_req = 1'b1; m_waitrequest = 1'b0;
            m_readdatavalid = 1'b1; m_readdata = 32'h77;
            #2;
            if (r0_grant && r1_grant) both++;
            else if (r0_grant) begin order[ng] = 1'b0; ng++; end
            else if (r1_grant) begin order[ng] = 1'b1; ng++; end
        end
        drained = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            @(negedge clk);
            r0_req = 1'b0; r1_req = 1'b0;
            #2;
            if (!busy) drained = 1'b1;
        end
        m_readdatavalid = 1'b0;
        chk("contention grants", 64'(ng), 64'd4);
        chk("contention double grant", 64'(both), 64'd0);
        chk("contention drain", 64'(drained), 64'd1);
`ifdef FETCH_ARB_BG_PRIORITY_EN
        exp_order = 4'b0000;
`else
        exp_order = 4'b1010;   // bit k = winner of burst k: r0, r1, r0, r1
`endif
        for (int k = 0; k < 4; k++)
            chk($sformatf("contention order[%0d]", k), 64'(order[k]), 64'(exp_order[k]));

        // Max burst with gapped beats, 20 beats offered: exactly 16 taken.
        burst(1'b0, 30'h500, 5'd16, 20, 1'b1, granted, bc_seen, nv, nd, done_at,
              stray, bad_rd, busy_at_done, busy_after);
        chk("max granted", 64'(granted), 64'd1);
        chk("max bc", 64'(bc_seen), 64'd16);
        chk("max rdvalid", 64'(nv), 64'd16);
        chk("max done", 64'(nd), 64'd1);
        chk("max done beat", 64'(done_at), 64'd16);
        chk("max data", 64'(bad_rd), 64'd0);
        chk("max stray", 64'(stray), 64'd0);
        chk("max busy at done", 64'(busy_at_done), 64'd1);
        chk("max busy after done", 64'(busy_after), 64'd0);

        // Zero burstcount: driven as 0 on the bus, runs as 16 beats.
        burst(1'b1, 30'h600, 5'd0, 20, 1'b0, granted, bc_seen, nv, nd, done_at,
              stray, bad_rd, busy_at_done, busy_after);
        chk("zero granted", 64'(granted), 64'd1);
        chk("zero bc on bus", 64'(bc_seen), 64'd0);
        chk("zero rdvalid", 64'(nv), 64'd16);
        chk("zero done beat", 64'(done_at), 64'd16);
        chk("zero done", 64'(nd), 64'd1);
        chk("zero data", 64'(bad_rd), 64'd0);
        chk("zero stray", 64'(stray), 64'd0);

        // Reset after 3 of 16 beats: asynchronous abort, stray beats ignored.
        r0_address = 30'h300; r0_burstcount = 5'd16;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            r0_req = 1'b1; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
            #2;
            if (r0_grant) got = 1'b1;
        end
        chk("rst grant", 64'(got), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            r0_req = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'hD0 + 32'(k);
            #2;
        end
        @(negedge clk);
        m_readdatavalid = 1'b0;
        #2;
        chk("rst pre rdvalid", 64'({r0_rdvalid, busy}), 64'b11);
        chk("rst pre data", 64'(rd_data), 64'hD2);
        #1 reset = 1'b1;
        #1 chk_reset("mid reset");
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            m_readdatavalid = 1'b1; m_readdata = 32'hEE;
            #2;
            if (r0_rdvalid | r1_rdvalid | r0_done | r1_done | busy | (rd_data != 32'h0)) stray++;
        end
        m_readdatavalid = 1'b0;
        chk("rst late beats", 64'(stray), 64'd0);
        burst(1'b1, 30'h400, 5'd2, 2, 1'b0, granted, bc_seen, nv, nd, done_at,
              stray, bad_rd, busy_at_done, busy_after);
        chk("post-rst granted", 64'(granted), 64'd1);
        chk("post-rst rdvalid", 64'(nv), 64'd2);
        chk("post-rst done", 64'({nd[3:0], done_at[3:0]}), 64'h12);
        chk("post-rst data/stray", 64'({bad_rd[7:0], stray[7:0]}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_arbiter
